sbox_ctx_sequencer: RTL and testbench

- Context scheduler and configurator for the 4-port sbox (north/west/south/east, 32-bit).
- Holds a small table of routing contexts, loaded through a valid/ready write port. Each context gives a source per output, an output-enable mask and a dwell time.
- On command, steps the sbox through the contexts, holding each one for its programmed number of cycles. Sequencing either loops or stops after the context marked last.

---
 rtl/sbox_ctx_sequencer.sv | 147 ++++++++++++++
 tb/tb_sbox_ctx_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_ctx_sequencer.sv
// sbox_ctx_sequencer: routing-context table and dwell-timed sequencer
// that drives the route/enable selects of a 4-port 32-bit sbox.
module sbox_ctx_sequencer #(
   parameter int NUM_CTX = 4,
   parameter int CNT_W   = 16,
   parameter bit LOOP    = 1'b1,
   localparam int IW     = $clog2(NUM_CTX)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_run,
   input  logic             cmd_clear,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IW-1:0]    cfg_idx,
   input  logic [7:0]       cfg_route,
   input  logic [3:0]       cfg_mask,
   input  logic [CNT_W-1:0] cfg_dwell,
   input  logic             cfg_last,
   output logic [7:0]       sbox_route,
   output logic [3:0]       sbox_oen,
   output logic [IW-1:0]    ctx_id,
   output logic             ctx_switch,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t           state_q;
   logic [IW-1:0]    ctx_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       route_q;
   logic [3:0]       oen_q;
   logic             sw_q;

   logic [7:0]       rt_q [NUM_CTX];
   logic [3:0]       mk_q [NUM_CTX];
   logic [CNT_W-1:0] dw_q [NUM_CTX];
   logic [NUM_CTX-1:0] last_q;

   logic             wr;
   logic             hit;
   logic [IW-1:0]    nxt_idx;
   logic [IW-1:0]    sel_idx;
   logic [7:0]       e_route;
   logic [3:0]       e_mask;
   logic [CNT_W-1:0] e_dwell;
   logic [CNT_W-1:0] e_load;

   assign cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign wr        = cfg_valid && cfg_ready && !cmd_clear;

   // Entry about to be applied; a same-cycle write to it is forwarded.
   assign nxt_idx = last_q[ctx_q] ? '0 : ctx_q + IW'(1);
   assign sel_idx = (state_q == S_RUN) ? nxt_idx : '0;
   assign hit     = wr && (cfg_idx == sel_idx);
   assign e_route = hit ? cfg_route : rt_q[sel_idx];
   assign e_mask  = hit ? cfg_mask  : mk_q[sel_idx];
   assign e_dwell = hit ? cfg_dwell : dw_q[sel_idx];
   assign e_load  = (e_dwell == '0) ? CNT_W'(1) : e_dwell;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CTX; i++) begin
            rt_q[i] <= '0;
            mk_q[i] <= '0;
            dw_q[i] <= '0;
         end
         last_q <= '0;
      end else if (wr) begin
         rt_q[cfg_idx]   <= cfg_route;
         mk_q[cfg_idx]   <= cfg_mask;
         dw_q[cfg_idx]   <= cfg_dwell;
         last_q[cfg_idx] <= cfg_last;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ctx_q   <= '0;
         cnt_q   <= '0;
         route_q <= '0;
         oen_q   <= '0;
         sw_q    <= 1'b0;
      end else begin
         sw_q <= 1'b0;
         if (cmd_clear) begin
            state_q <= S_IDLE;
            ctx_q   <= '0;
            cnt_q   <= '0;
            route_q <= '0;
            oen_q   <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (cmd_run) begin
                     state_q <= S_RUN;
                     ctx_q   <= sel_idx;
                     route_q <= e_route;
                     oen_q   <= e_mask;
                     cnt_q   <= e_load;
                     sw_q    <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (!cmd_run) begin
                     state_q <= S_PAUSE;
                  end else if (cnt_q != CNT_W'(1)) begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end else if (last_q[ctx_q] && !LOOP) begin
                     state_q <= S_DONE;
                     oen_q   <= '0;
                     cnt_q   <= '0;
                  end else begin
                     ctx_q   <= sel_idx;
                     route_q <= e_route;
                     oen_q   <= e_mask;
                     cnt_q   <= e_load;
                     sw_q    <= 1'b1;
                  end
               end
               S_PAUSE: begin
                  if (cmd_run) state_q <= S_RUN;
               end
               S_DONE: begin
                  if (!cmd_run) begin
                     state_q <= S_IDLE;
                     ctx_q   <= '0;
                     route_q <= '0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign sbox_route = route_q;
   assign sbox_oen   = oen_q;
   assign ctx_id     = ctx_q;
   assign ctx_switch = sw_q;
   assign busy       = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sbox_ctx_sequencer.sv
// Bench for sbox_ctx_sequencer: looping and stopping instances share
// stimulus; a behavioural model fills queues that a monitor drains.
module tb_sbox_ctx_sequencer;

   localparam int N = 4;
   localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

   typedef struct packed {
      logic [7:0] route;
      logic [3:0] oen;
      logic [1:0] ctx;
      logic       sw;
      logic       busy;
      logic       done;
      logic       ready;
   } exp_t;

   logic clk, rst_n, rst_lvl;
   logic cmd_run, cmd_clear, cfg_valid, cfg_last;
   logic [1:0] cfg_idx;
   logic [7:0] cfg_route;
   logic [3:0] cfg_mask;
   logic [15:0] cfg_dwell;

   logic [7:0] a_route, b_route;
   logic [3:0] a_oen, b_oen;
   logic [1:0] a_ctx, b_ctx;
   logic a_sw, a_busy, a_done, a_ready;
   logic b_sw, b_busy, b_done, b_ready;
   exp_t act0, act1;

   int nvec = 0;
   int nbad = 0;
   exp_t q0[$];
   exp_t q1[$];

   int m_mode[2], m_ctx[2], m_rem[2];
   logic [7:0] m_route[2];
   logic [3:0] m_oen[2];
   logic m_sw[2];
   logic [7:0] t_route[2][N];
   logic [3:0] t_mask[2][N];
   int t_dwell[2][N];
   logic t_last[2][N];

   sbox_ctx_sequencer #(.NUM_CTX(N), .CNT_W(16), .LOOP(1'b1)) u_loop (
      .clk(clk), .reset(rst_n), .cmd_run(cmd_run), .cmd_clear(cmd_clear),
      .cfg_valid(cfg_valid), .cfg_ready(a_ready), .cfg_idx(cfg_idx),
      .cfg_route(cfg_route), .cfg_mask(cfg_mask), .cfg_dwell(cfg_dwell),
      .cfg_last(cfg_last), .sbox_route(a_route), .sbox_oen(a_oen),
      .ctx_id(a_ctx), .ctx_switch(a_sw), .busy(a_busy), .done(a_done));

   sbox_ctx_sequencer #(.NUM_CTX(N), .CNT_W(16), .LOOP(1'b0)) u_stop (
      .clk(clk), .reset(rst_n), .cmd_run(cmd_run), .cmd_clear(cmd_clear),
      .cfg_valid(cfg_valid), .cfg_ready(b_ready), .cfg_idx(cfg_idx),
      .cfg_route(cfg_route), .cfg_mask(cfg_mask), .cfg_dwell(cfg_dwell),
      .cfg_last(cfg_last), .sbox_route(b_route), .sbox_oen(b_oen),
      .ctx_id(b_ctx), .ctx_switch(b_sw), .busy(b_busy), .done(b_done));

   assign act0 = {a_route, a_oen, a_ctx, a_sw, a_busy, a_done, a_ready};
   assign act1 = {b_route, b_oen, b_ctx, b_sw, b_busy, b_done, b_ready};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void m_reset(int i);
      m_mode[i] = IDLE; m_ctx[i] = 0; m_rem[i] = 0;
      m_route[i] = '0; m_oen[i] = '0; m_sw[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
         t_route[i][k] = '0; t_mask[i][k] = '0;
         t_dwell[i][k] = 0; t_last[i][k] = 1'b0;
      end
   endfunction

   function automatic void m_apply(int i, int c);
      m_mode[i] = RUN; m_ctx[i] = c; m_sw[i] = 1'b1;
      m_route[i] = t_route[i][c]; m_oen[i] = t_mask[i][c];
      m_rem[i] = (t_dwell[i][c] == 0) ? 1 : t_dwell[i][c];
   endfunction

   function automatic void m_step(int i);
      m_sw[i] = 1'b0;
      if (cmd_clear) begin
         m_mode[i] = IDLE; m_ctx[i] = 0; m_rem[i] = 0;
         m_route[i] = '0; m_oen[i] = '0;
         return;
      end
      if ((m_mode[i] == IDLE || m_mode[i] == DONE) && cfg_valid) begin
         t_route[i][cfg_idx] = cfg_route; t_mask[i][cfg_idx] = cfg_mask;
         t_dwell[i][cfg_idx] = int'(cfg_dwell); t_last[i][cfg_idx] = cfg_last;
      end
      case (m_mode[i])
         IDLE: if (cmd_run) m_apply(i, 0);
         RUN: begin
            if (!cmd_run) m_mode[i] = PAUSE;
            else if (m_rem[i] > 1) m_rem[i]--;
            else if (!t_last[i][m_ctx[i]]) m_apply(i, (m_ctx[i] + 1) % N);
            else if (i == 0) m_apply(i, 0);
            else begin m_mode[i] = DONE; m_oen[i] = '0; end
         end
         PAUSE: if (cmd_run) m_mode[i] = RUN;
         DONE: if (!cmd_run) begin
            m_mode[i] = IDLE; m_ctx[i] = 0; m_route[i] = '0;
         end
         default: ;
      endcase
   endfunction

   function automatic exp_t m_out(int i);
      exp_t e;
      e.route = m_route[i]; e.oen = m_oen[i]; e.ctx = 2'(m_ctx[i]);
      e.sw = m_sw[i];
      e.busy = (m_mode[i] == RUN) || (m_mode[i] == PAUSE);
      e.done = (m_mode[i] == DONE);
      e.ready = (m_mode[i] == IDLE) || (m_mode[i] == DONE);
      return e;
   endfunction

   task automatic chk(input string nm, input exp_t a, input exp_t e);
      nvec++;
      if (a !== e) begin
         nbad++;
         $display("FAIL %s t=%0t got rt=%h oen=%h ctx=%0d sw=%b busy=%b done=%b rdy=%b exp rt=%h oen=%h ctx=%0d sw=%b busy=%b done=%b rdy=%b",
                  nm, $time, a.route, a.oen, a.ctx, a.sw, a.busy, a.done, a.ready,
                  e.route, e.oen, e.ctx, e.sw, e.busy, e.done, e.ready);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q0.size() > 0) begin e = q0.pop_front(); chk("loop", act0, e); end
         if (q1.size() > 0) begin e = q1.pop_front(); chk("stop", act1, e); end
      end
   end

   task automatic cyc(input logic run, input logic clr, input logic vld,
                      input int idx, input logic [7:0] rt,
                      input logic [3:0] mk, input int dw, input logic lst);
      @(negedge clk);
      rst_n = rst_lvl;
      cmd_run = run; cmd_clear = clr; cfg_valid = vld;
      cfg_idx = idx[1:0]; cfg_route = rt; cfg_mask = mk;
      cfg_dwell = dw[15:0]; cfg_last = lst;
      for (int i = 0; i < 2; i++) begin
         if (!rst_lvl) m_reset(i);
         else m_step(i);
      end
      q0.push_back(m_out(0));
      q1.push_back(m_out(1));
   endtask

   task automatic step(input logic run, input logic clr);
      cyc(run, clr, 1'b0, 0, 8'h00, 4'h0, 0, 1'b0);
   endtask

   task automatic wr(input int idx, input logic [7:0] rt, input logic [3:0] mk,
                     input int dw, input logic lst);
      cyc(1'b0, 1'b0, 1'b1, idx, rt, mk, dw, lst);
   endtask

   // Called right after cyc(): reset lands mid-cycle, before the next edge.
   task automatic async_rst();
      #2;
      rst_lvl = 1'b0;
      rst_n = 1'b0;
      void'(q0.pop_back());
      void'(q1.pop_back());
      m_reset(0);
      m_reset(1);
      q0.push_back(m_out(0));
      q1.push_back(m_out(1));
      #1;
      chk("async_rst_loop", act0, m_out(0));
      chk("async_rst_stop", act1, m_out(1));
   endtask

   initial begin
      int guard;
      rst_lvl = 1'b0;
      rst_n = 1'b1;
      cmd_run = 0; cmd_clear = 0; cfg_valid = 0; cfg_last = 0;
      cfg_idx = '0; cfg_route = '0; cfg_mask = '0; cfg_dwell = '0;
      m_reset(0);
      m_reset(1);
      #1 rst_n = 1'b0;

      repeat (3) step(1'b0, 1'b0);
      rst_lvl = 1'b1;
      step(1'b0, 1'b0);

      wr(0, 8'hE4, 4'hF, 3, 1'b0);
      wr(1, 8'h1B, 4'h5, 2, 1'b1);
      repeat (8) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      step(1'b0, 1'b1);

      for (int k = 0; k < N; k++)
         wr(k, 8'($urandom), 4'($urandom), 0, 1'b0);
      repeat (6) step(1'b1, 1'b0);
      step(1'b0, 1'b1);

      wr(0, 8'h39, 4'hA, 5, 1'b0);
      wr(1, 8'hC6, 4'h3, 2, 1'b1);
      repeat (2) step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      step(1'b0, 1'b1);

      wr(0, 8'hE4, 4'hF, 3, 1'b0);
      wr(1, 8'h1B, 4'h5, 2, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1, 8'hFF, 4'h3, 7, 1'b0);
      repeat (6) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      guard = 0;
      while (!(m_mode[0] == RUN && m_rem[0] == 1) && guard < 20) begin
         step(1'b1, 1'b0);
         guard++;
      end
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      repeat (4) step(1'b1, 1'b0);
      async_rst();
      step(1'b1, 1'b0);
      rst_lvl = 1'b1;
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b1);

      for (int n = 0; n < 1500; n++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r < 2 && rst_lvl) begin
            async_rst();
         end else begin
            if (!rst_lvl && r < 100) rst_lvl = 1'b1;
            cyc($urandom_range(0, 99) < 80, $urandom_range(0, 39) == 0,
                1'($urandom), int'($urandom_range(0, N - 1)),
                8'($urandom), 4'($urandom), int'($urandom_range(0, 4)),
                $urandom_range(0, 3) == 0);
         end
      end
      rst_lvl = 1'b1;
      repeat (3) step(1'b0, 1'b1);

      @(posedge clk); #3;
      @(posedge clk); #3;
      nvec++;
      if (q0.size() != 0 || q1.size() != 0) begin
         nbad++;
         $display("FAIL drain left=%0d/%0d required=0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
